serial_frame_tx: RTL and testbench
==================================

# serial_frame_tx

Bit-serial frame transmitter: accepts a parallel word over a valid/ready handshake and emits it as a framed serial stream on `dout`. Each frame is a start bit, the data MSB-first, and a stop bit. It is the stimulus-side counterpart of the team's serial sequence-detector FSMs: its `dout` drives their `din` directly. It is implemented as a Moore FSM with registered outputs, using the three-process style.

## Interface
- `DATA_W`, default 8: data bits per frame; legal range 2..32.
- `clk`  input  1  system clock; all state changes on the rising edge.
- `rst`  input  1  reset; asynchronous, active-low.
- `din_valid`  input  1  `din_data` holds a word to send.
- `din_data`  input  `DATA_W`  word to serialise.
- `din_ready`  output  1  transmitter can accept a word this cycle.
- `dout`  output  1  serial line; idle level 0.
- `busy`  output  1  a frame is on the line (start through stop).

## Operation
- States: `IDLE`, `START`, `DATA`, `PARITY` (present only with the macro), `STOP`.
- Reset (`rst`=0) forces the following immediately:
  - state `IDLE`;
  - `dout`=0, `busy`=0, `din_ready`=0;
  - shift register and bit counter cleared.
- `din_ready` is a registered Moore output. It is 1 only in `IDLE` and rises on the first clock edge after `rst` deasserts.
- Accept: a rising edge with `din_valid`=1 and `din_ready`=1 loads `din_data` into the shift register and moves to `START`.
- `din_valid` while `din_ready`=0 is ignored, and no word is queued. Changes to `din_data` after the accept have no effect.
- `START`: `dout`=1 for one cycle, then go to `DATA`.
- `DATA`:
  - `dout` = shift register MSB.
  - Shift left once per cycle.
  - The bit counter (`$clog2(DATA_W)` bits) counts 0..`DATA_W`-1 and does not wrap mid-frame.
  - At count `DATA_W`-1, go to `PARITY` or `STOP`.
- `STOP`: `dout`=0 for one cycle, then go to `IDLE`.
- `busy`=1 in `START`, `DATA`, `PARITY` and `STOP`.
- `IDLE` with `din_valid` held high accepts at the first `IDLE` edge. Back-to-back frames are therefore separated by exactly one `IDLE` cycle, so the line is low for stop + idle = 2 cycles.
- Reset asserted mid-frame aborts immediately: the frame is dropped and `dout` goes to 0 asynchronously. There is no partial-frame recovery.

## Timing
- All outputs come from flops; there is no combinational path from an input to an output.
- Let edge k be the accept edge. Edges are numbered from there:
  - start bit: k → k+1;
  - data bit i (MSB = i 0): edges k+1+i → k+2+i;
  - stop bit: k+1+`DATA_W` → k+2+`DATA_W`;
  - `din_ready`=1 again from edge k+2+`DATA_W`.
- Frame length is `DATA_W`+2 cycles, or `DATA_W`+3 with parity.
- Minimum accept period is `DATA_W`+3 cycles, or `DATA_W`+4 with parity.
- `din_ready` falls on edge k, in the same edge as the accept. No second accept is possible at k+1.

## Configuration
- Macro: `SERIAL_FRAME_TX_PARITY_EN`.
- Defined:
  - The `PARITY` state is inserted between `DATA` and `STOP`.
  - `dout` = even parity (XOR of all data bits) for one cycle.
  - Parity is computed at load from `din_data` and stored in one flop.
- Undefined: the `PARITY` state, the parity flop and its logic are absent, and `DATA` goes directly to `STOP`.

## Structure
- Package `serial_frame_pkg` holds:
  - the state encoding as localparams (`IDLE`=0, `START`=1, `DATA`=2, `PARITY`=3, `STOP`=4; 3-bit state);
  - `START_BIT`=1, `STOP_BIT`=0 and `IDLE_LEVEL`=0, shared with the detector-side blocks.
- One sub-module: `serial_frame_shreg`, a `DATA_W` load/shift-left register with an MSB output and async active-low clear. The FSM drives its load and shift strobes.

## Test plan
All scenarios use `DATA_W`=8 and a 20 ns clock.
1. Hold `rst`=0 for 40 ns → `dout`=0, `busy`=0, `din_ready`=0. First edge after release → `din_ready`=1. No activity on `dout` while `din_valid`=0.
2. Send `8'hA5` → `dout` over 10 cycles is 1,1,0,1,0,0,1,0,1,0. `busy`=1 for exactly those 10 cycles. `din_ready`=1 on the next edge.
3. Hold `din_valid`=1 with `8'h00`, then `8'hFF` after the first accept → two complete frames. Exactly one `IDLE` cycle between them. The second frame's data is all ones.
4. Change `din_data` to `8'h3C` mid-frame after accepting `8'hC3` → the transmitted data is still `8'hC3`. The pulse on `din_valid` is ignored while busy.
5. Assert `rst` during data bit 4 of `8'hFF` → `dout`=0 and `busy`=0 immediately. After release, a new `8'h81` frame is sent cleanly: 1,1,0,0,0,0,0,0,1,0.
6. With `SERIAL_FRAME_TX_PARITY_EN` defined, send `8'hA5` then `8'h07` → parity bits 0 and 1 respectively, placed between bit 7 and stop. Frame length is 11 cycles.

Source files
------------

// File: rtl/serial_frame_tx_pkg.sv
// Shared encodings for the serial frame transmitter and its detector-side peers.
// The optional parity bit is enabled by SERIAL_FRAME_TX_PARITY_EN.
package serial_frame_pkg;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_IDLE   = 3'd0;
  localparam logic [STATE_W-1:0] ST_START  = 3'd1;
  localparam logic [STATE_W-1:0] ST_DATA   = 3'd2;
  localparam logic [STATE_W-1:0] ST_PARITY = 3'd3;
  localparam logic [STATE_W-1:0] ST_STOP   = 3'd4;

  // Line levels; the detector FSMs key on these same values.
  localparam logic START_BIT  = 1'b1;
  localparam logic STOP_BIT   = 1'b0;
  localparam logic IDLE_LEVEL = 1'b0;

  typedef enum logic [STATE_W-1:0] {
    IDLE   = ST_IDLE,
    START  = ST_START,
    DATA   = ST_DATA,
    PARITY = ST_PARITY,
    STOP   = ST_STOP
  } state_e;

  // Registered Moore outputs, computed together from the next state.
  typedef struct packed {
    logic dout;
    logic busy;
    logic ready;
  } tx_out_t;

  function automatic int cnt_w(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_frame_tx_if.sv
// Parallel-in / serial-out bus of the frame transmitter.
// The slave modport is the transmitter side; the master is the word producer.
interface serial_frame_tx_if #(
  parameter int DATA_W = 8
);
  logic              din_valid;
  logic [DATA_W-1:0] din_data;
  logic              din_ready;
  logic              dout;
  logic              busy;

  modport master (
    output din_valid, din_data,
    input  din_ready, dout, busy
  );

  modport slave (
    input  din_valid, din_data,
    output din_ready, dout, busy
  );
endinterface

// File: rtl/serial_frame_shreg.sv
// DATA_W-bit load / shift-left register feeding the serial line MSB-first.
// Load has priority over shift; async active-low clear.
module serial_frame_shreg #(
  parameter int DATA_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_load,
  input  logic              i_shift,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_msb
);

  logic [DATA_W-1:0] r_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)     r_q <= '0;
    else if (i_load)  r_q <= i_data;
    else if (i_shift) r_q <= {r_q[DATA_W-2:0], 1'b0};
  end

  assign o_msb = r_q[DATA_W-1];

endmodule

// File: rtl/serial_frame_tx.sv
// Framed bit-serial transmitter: start bit, data MSB-first, optional even parity
// (SERIAL_FRAME_TX_PARITY_EN), stop bit. All outputs are registered Moore outputs.
module serial_frame_tx
  import serial_frame_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  serial_frame_tx_if.slave bus
);

  localparam int              CNT_W    = cnt_w(DATA_W);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

  state_e           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  tx_out_t          r_out, w_out_nxt;
  logic             w_load, w_shift, w_msb, w_accept;

  serial_frame_shreg #(.DATA_W(DATA_W)) u_shreg (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_load  (w_load),
    .i_shift (w_shift),
    .i_data  (bus.din_data),
    .o_msb   (w_msb)
  );

  // din_ready is registered, so accepting only depends on the flop and din_valid.
  assign w_accept = bus.din_valid && r_out.ready;

`ifdef SERIAL_FRAME_TX_PARITY_EN
  logic r_par;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        r_par <= 1'b0;
    else if (w_load) r_par <= ^bus.din_data;
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_out   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_out   <= w_out_nxt;
    end
  end

  // Outputs are decoded from the next state, so each bit appears on the line
  // during the cycle that state occupies.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_load          = 1'b0;
    w_shift         = 1'b0;
    w_out_nxt.dout  = IDLE_LEVEL;
    w_out_nxt.busy  = 1'b1;
    w_out_nxt.ready = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt    = START;
          w_load         = 1'b1;
          w_out_nxt.dout = START_BIT;
        end else begin
          w_out_nxt.busy  = 1'b0;
          w_out_nxt.ready = 1'b1;
        end
      end

      START: begin
        w_state_nxt    = DATA;
        w_cnt_nxt      = '0;
        w_out_nxt.dout = w_msb;
        w_shift        = 1'b1;
      end

      // The MSB already went out on leaving START; DATA emits the remaining bits.
      DATA: begin
        if (r_cnt == LAST_CNT) begin
`ifdef SERIAL_FRAME_TX_PARITY_EN
          w_state_nxt    = PARITY;
          w_out_nxt.dout = r_par;
`else
          w_state_nxt    = STOP;
          w_out_nxt.dout = STOP_BIT;
`endif
        end else begin
          w_out_nxt.dout = w_msb;
          w_shift        = 1'b1;
          w_cnt_nxt      = r_cnt + 1'b1;
        end
      end

`ifdef SERIAL_FRAME_TX_PARITY_EN
      PARITY: begin
        w_state_nxt    = STOP;
        w_out_nxt.dout = STOP_BIT;
      end
`endif

      STOP: begin
        w_state_nxt     = IDLE;
        w_cnt_nxt       = '0;
        w_out_nxt.busy  = 1'b0;
        w_out_nxt.ready = 1'b1;
      end

      default: begin
        w_state_nxt     = IDLE;
        w_cnt_nxt       = '0;
        w_out_nxt.busy  = 1'b0;
        w_out_nxt.ready = 1'b1;
      end
    endcase
  end

  assign bus.dout      = r_out.dout;
  assign bus.busy      = r_out.busy;
  assign bus.din_ready = r_out.ready;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Self-checking bench for serial_frame_tx (DATA_W=8, 20 ns clock); honours
// SERIAL_FRAME_TX_PARITY_EN for frame length and expected parity bits.
module tb_serial_frame_tx;

`ifdef SERIAL_FRAME_TX_PARITY_EN
  localparam int FLEN = 11;
`else
  localparam int FLEN = 10;
`endif

  typedef struct {
    logic [7:0]  data;
    logic [10:0] bits;   // line bits in time order, MSB-aligned at bit FLEN-1
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  vec_t tbl [4];

  serial_frame_tx_if #(.DATA_W(8)) bus ();

  serial_frame_tx #(.DATA_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #10 clk = ~clk;

  task automatic chk(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  // Reference frame: start, data MSB-first, optional even parity, stop.
  function automatic logic [10:0] model_frame(input logic [7:0] d);
    bit          q[$];
    logic [10:0] r;
    r = '0;
    q.push_back(1'b1);
    for (int i = 7; i >= 0; i--) q.push_back(d[i]);
`ifdef SERIAL_FRAME_TX_PARITY_EN
    q.push_back(^d);
`endif
    q.push_back(1'b0);
    foreach (q[i]) r = {r[9:0], q[i]};
    return r;
  endfunction

  // Called at a negedge; returns at the negedge right after the accept edge.
  task automatic accept(input logic [7:0] d);
    int n;
    n = 0;
    bus.din_valid = 1'b1;
    bus.din_data  = d;
    while (bus.din_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept_wait_ready", bus.din_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_frame(input string tag, input logic [10:0] bits,
                             input int poke_at, input logic [7:0] poke);
    for (int j = 0; j < FLEN; j++) begin
      chk($sformatf("%s dout[%0d]", tag, j), bus.dout, bits[FLEN-1-j]);
      chk($sformatf("%s busy[%0d]", tag, j), bus.busy, 1'b1);
      chk($sformatf("%s ready[%0d]", tag, j), bus.din_ready, 1'b0);
      if (poke_at >= 0 && j == poke_at) begin
        bus.din_data  = poke;
        bus.din_valid = 1'b1;
      end else if (poke_at >= 0 && j == poke_at + 1) begin
        bus.din_valid = 1'b0;
      end
      @(negedge clk);
    end
    chk($sformatf("%s end busy", tag), bus.busy, 1'b0);
    chk($sformatf("%s end ready", tag), bus.din_ready, 1'b1);
    chk($sformatf("%s end dout", tag), bus.dout, 1'b0);
  endtask

  task automatic idle_check(input string tag, input int n);
    for (int j = 0; j < n; j++) begin
      chk($sformatf("%s idle dout[%0d]", tag, j), bus.dout, 1'b0);
      chk($sformatf("%s idle busy[%0d]", tag, j), bus.busy, 1'b0);
      chk($sformatf("%s idle ready[%0d]", tag, j), bus.din_ready, 1'b1);
      @(negedge clk);
    end
  endtask

  initial begin
    logic [7:0] rd;
    int         gap;

`ifdef SERIAL_FRAME_TX_PARITY_EN
    tbl[0] = '{8'hA5, 11'b11010010100};
    tbl[1] = '{8'h07, 11'b10000011110};
    tbl[2] = '{8'h81, 11'b11000000100};
    tbl[3] = '{8'hC3, 11'b11100001100};
`else
    tbl[0] = '{8'hA5, 11'b01101001010};
    tbl[1] = '{8'h07, 11'b01000001110};
    tbl[2] = '{8'h81, 11'b01100000010};
    tbl[3] = '{8'hC3, 11'b01110000110};
`endif

    bus.din_valid = 1'b0;
    bus.din_data  = 8'h00;

    // Reset held for 40 ns, released on a falling edge.
    #1 rst = 1'b0;
    #4;
    chk("rst dout", bus.dout, 1'b0);
    chk("rst busy", bus.busy, 1'b0);
    chk("rst ready", bus.din_ready, 1'b0);
    @(negedge clk);
    chk("rst ready t20", bus.din_ready, 1'b0);
    @(negedge clk);
    chk("rst ready t40", bus.din_ready, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    idle_check("post_rst", 4);

    // Table vectors, one isolated frame each.
    foreach (tbl[i]) begin
      accept(tbl[i].data);
      bus.din_valid = 1'b0;
      check_frame($sformatf("tbl%0d", i), tbl[i].bits, -1, 8'h00);
      idle_check($sformatf("tbl%0d", i), 1);
    end

    // Back-to-back with din_valid held: exactly one idle cycle between frames.
    accept(8'h00);
    bus.din_data = 8'hFF;
    check_frame("b2b0", model_frame(8'h00), -1, 8'h00);
    accept(8'hFF);
    bus.din_valid = 1'b0;
    check_frame("b2b1", model_frame(8'hFF), -1, 8'h00);
    idle_check("b2b", 2);

    // Data change and valid pulse while busy must not disturb or queue.
    accept(8'hC3);
    bus.din_valid = 1'b0;
    check_frame("chg", tbl[3].bits, 3, 8'h3C);
    idle_check("chg", 3);

    // Reset during data bit 4 of 0xFF aborts at once; next frame is clean.
    accept(8'hFF);
    bus.din_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("abort bit4 dout", bus.dout, 1'b1);
    chk("abort bit4 busy", bus.busy, 1'b1);
    #3 rst = 1'b0;
    #1;
    chk("abort dout", bus.dout, 1'b0);
    chk("abort busy", bus.busy, 1'b0);
    chk("abort ready", bus.din_ready, 1'b0);
    @(negedge clk);
    chk("abort held dout", bus.dout, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    idle_check("abort", 2);
    accept(8'h81);
    bus.din_valid = 1'b0;
    check_frame("rst_rec", tbl[2].bits, -1, 8'h00);

    // Randomized words, gaps and held valid against the reference frame.
    for (int it = 0; it < 40; it++) begin
      rd  = 8'($urandom);
      gap = $urandom_range(0, 2);
      if (gap > 0) begin
        bus.din_valid = 1'b0;
        idle_check($sformatf("rnd%0d", it), gap);
      end
      accept(rd);
      bus.din_data = 8'($urandom);
      if ($urandom_range(0, 1) == 0) bus.din_valid = 1'b0;
      check_frame($sformatf("rnd%0d", it), model_frame(rd), -1, 8'h00);
    end
    bus.din_valid = 1'b0;
    idle_check("final", 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule
